// File: rtl/router_output_channel.sv
// ---------------------------------------------------------------------------
// router_output_channel
//
// Store-and-forward output buffer for one router channel. Bytes qualified by
// packet_valid_in are written into a circular byte FIFO. A packet becomes
// readable only after its parity byte has been stored (committed). The reader
// pops bytes with read_enb while vld_chan is high. suspend_data_in tells the
// packet source that free space is running low. overflow is a sticky flag
// that records a packet dropped because the FIFO filled up.
//
// Packet format: header {L[5:0], addr[1:0]}, L payload bytes, then one parity
// byte equal to the XOR of the header and all payload bytes.
//
// Optional feature macro: ROUTER_OUTPUT_CHANNEL_PARITY_CHECK_EN
//   defined   : the parity byte is checked and err pulses for one cycle on a
//               mismatch. The packet is committed either way.
//   undefined : no parity accumulator is built and err is tied low.
//
// Ports:
//   clock           in   single rising-edge clock
//   reset           in   asynchronous active-low reset
//   data_in         in   [7:0] byte stream from the input stage
//   packet_valid_in in   qualifies data_in
//   channel         out  [7:0] registered read data
//   vld_chan        out  at least one complete packet is stored
//   read_enb        in   reader pop request
//   err             out  one-cycle parity-error pulse
//   suspend_data_in out  free entries below SUSPEND_FREE
//   overflow        out  sticky packet-dropped flag
// ---------------------------------------------------------------------------
module router_output_channel #(
    parameter int DEPTH        = 128,
    parameter int AW           = 7,
    parameter int SUSPEND_FREE = 65
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       packet_valid_in,
    output logic [7:0] channel,
    output logic       vld_chan,
    input  logic       read_enb,
    output logic       err,
    output logic       suspend_data_in,
    output logic       overflow
);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_PAR   = 2'd2;
    localparam logic [1:0] W_DRAIN = 2'd3;

    localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [AW:0] SUSP_V   = (AW+1)'(SUSPEND_FREE);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    // Storage and state
    logic [7:0]  r_mem [DEPTH];
    logic [1:0]  r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_wr_start;
    logic [AW:0] r_wr_commit;
    logic [AW:0] r_rd_ptr;
    logic [5:0]  r_remain;
    logic [AW:0] r_pkt_count;
    logic [6:0]  r_rd_cnt;
    logic        r_rd_in_pkt;
    logic [7:0]  r_channel;
    logic        r_vld;
    logic        r_susp;
    logic        r_ovf;

    // Combinational helpers
    logic [AW:0] w_occ;
    logic [AW:0] w_free;
    logic        w_full;
    logic        w_wr_try;
    logic        w_wr_en;
    logic        w_ovf_ev;
    logic        w_commit;
    logic        w_pop;
    logic        w_last_pop;
    logic [7:0]  w_rd_byte;

    logic [1:0]  w_state_nxt;
    logic [AW:0] w_wr_ptr_nxt;
    logic [AW:0] w_wr_start_nxt;
    logic [AW:0] w_wr_commit_nxt;
    logic [5:0]  w_remain_nxt;
    logic        w_ovf_nxt;
    logic [AW:0] w_rd_ptr_nxt;
    logic [6:0]  w_rd_cnt_nxt;
    logic        w_rd_in_pkt_nxt;
    logic [7:0]  w_channel_nxt;
    logic [AW:0] w_pkt_count_nxt;

    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_free     = DEPTH_V - w_occ;
    assign w_full     = (w_occ == DEPTH_V);
    // Every state except W_DRAIN treats a qualified byte as a write attempt.
    assign w_wr_try   = packet_valid_in && (r_state != W_DRAIN);
    assign w_wr_en    = w_wr_try && !w_full;
    assign w_ovf_ev   = w_wr_try && w_full;
    assign w_commit   = w_wr_en && (r_state == W_PAR);
    // The commit-pointer term keeps uncommitted bytes out of reach even if the
    // packet counter were ever to disagree with the pointers.
    assign w_pop      = read_enb && (r_pkt_count != {(AW+1){1'b0}}) && (r_rd_ptr != r_wr_commit);
    assign w_rd_byte  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_last_pop = w_pop && r_rd_in_pkt && (r_rd_cnt == 7'd1);

`ifdef ROUTER_OUTPUT_CHANNEL_PARITY_CHECK_EN
    logic [7:0] r_par_acc;
    logic [7:0] w_par_acc_nxt;
    logic       r_err;
    logic       w_err_nxt;

    function automatic logic [7:0] f_par_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Parity accumulator tracks the XOR of header and payload being written
    always_comb begin
        w_par_acc_nxt = r_par_acc;
        w_err_nxt     = 1'b0;
        if (w_wr_en && (r_state == W_IDLE)) begin
            w_par_acc_nxt = data_in;
        end else if (w_wr_en && (r_state == W_DATA)) begin
            w_par_acc_nxt = f_par_fold(r_par_acc, data_in);
        end else begin
            w_par_acc_nxt = r_par_acc;
        end
        if (w_commit) begin
            w_err_nxt = (data_in != r_par_acc);
        end else begin
            w_err_nxt = 1'b0;
        end
    end

    // Parity accumulator and error pulse registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_par_acc <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            r_par_acc <= w_par_acc_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // Write FSM next-state and write-pointer logic
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_wr_start_nxt  = r_wr_start;
        w_wr_commit_nxt = r_wr_commit;
        w_remain_nxt    = r_remain;
        w_ovf_nxt       = r_ovf;
        case (r_state)
            W_IDLE: begin
                if (w_ovf_ev) begin
                    // Nothing of the new packet is stored yet, so the rewind
                    // point is the current write pointer.
                    w_wr_start_nxt = r_wr_ptr;
                    w_ovf_nxt      = 1'b1;
                    w_state_nxt    = W_DRAIN;
                end else if (w_wr_en) begin
                    w_wr_start_nxt = r_wr_ptr;
                    w_wr_ptr_nxt   = r_wr_ptr + PTR_ONE;
                    w_remain_nxt   = data_in[7:2];
                    if (data_in[7:2] == 6'd0) begin
                        w_state_nxt = W_PAR;
                    end else begin
                        w_state_nxt = W_DATA;
                    end
                end else begin
                    w_state_nxt = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_ovf_ev) begin
                    w_wr_ptr_nxt = r_wr_start;
                    w_ovf_nxt    = 1'b1;
                    w_state_nxt  = W_DRAIN;
                end else if (w_wr_en) begin
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    w_remain_nxt = r_remain - 6'd1;
                    if (r_remain == 6'd1) begin
                        w_state_nxt = W_PAR;
                    end else begin
                        w_state_nxt = W_DATA;
                    end
                end else begin
                    w_state_nxt = W_DATA;
                end
            end
            W_PAR: begin
                if (w_ovf_ev) begin
                    w_wr_ptr_nxt = r_wr_start;
                    w_ovf_nxt    = 1'b1;
                    w_state_nxt  = W_DRAIN;
                end else if (w_wr_en) begin
                    w_wr_ptr_nxt    = r_wr_ptr + PTR_ONE;
                    w_wr_commit_nxt = r_wr_ptr + PTR_ONE;
                    w_state_nxt     = W_DRAIN;
                end else begin
                    w_state_nxt = W_PAR;
                end
            end
            W_DRAIN: begin
                if (!packet_valid_in) begin
                    w_state_nxt = W_IDLE;
                end else begin
                    w_state_nxt = W_DRAIN;
                end
            end
            default: begin
                w_state_nxt = W_IDLE;
            end
        endcase
    end

    // Read side: pointer, per-packet byte counter and output data
    always_comb begin
        w_rd_ptr_nxt    = r_rd_ptr;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_rd_in_pkt_nxt = r_rd_in_pkt;
        w_channel_nxt   = r_channel;
        if (w_pop) begin
            w_rd_ptr_nxt  = r_rd_ptr + PTR_ONE;
            w_channel_nxt = w_rd_byte;
            if (!r_rd_in_pkt) begin
                // Header: L payload bytes plus the parity byte remain.
                w_rd_cnt_nxt    = {1'b0, w_rd_byte[7:2]} + 7'd1;
                w_rd_in_pkt_nxt = 1'b1;
            end else if (r_rd_cnt == 7'd1) begin
                w_rd_cnt_nxt    = 7'd0;
                w_rd_in_pkt_nxt = 1'b0;
            end else begin
                w_rd_cnt_nxt    = r_rd_cnt - 7'd1;
                w_rd_in_pkt_nxt = 1'b1;
            end
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
    end

    // Complete-packet count; commit and final pop together cancel out
    always_comb begin
        case ({w_commit, w_last_pop})
            2'b10:   w_pkt_count_nxt = r_pkt_count + PTR_ONE;
            2'b01:   w_pkt_count_nxt = r_pkt_count - PTR_ONE;
            default: w_pkt_count_nxt = r_pkt_count;
        endcase
    end

    // FIFO storage write port (contents are not reset)
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= W_IDLE;
            r_wr_ptr    <= '0;
            r_wr_start  <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_remain    <= 6'd0;
            r_pkt_count <= '0;
            r_rd_cnt    <= 7'd0;
            r_rd_in_pkt <= 1'b0;
            r_channel   <= 8'd0;
            r_vld       <= 1'b0;
            r_susp      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_start  <= w_wr_start_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_remain    <= w_remain_nxt;
            r_pkt_count <= w_pkt_count_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_rd_in_pkt <= w_rd_in_pkt_nxt;
            r_channel   <= w_channel_nxt;
            r_vld       <= (w_pkt_count_nxt != {(AW+1){1'b0}});
            // Sampled from the occupancy the previous edge left behind.
            r_susp      <= (w_free < SUSP_V);
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign channel         = r_channel;
    assign vld_chan        = r_vld;
    assign suspend_data_in = r_susp;
    assign overflow        = r_ovf;

endmodule

// File: tb/tb_router_output_channel.sv
// ---------------------------------------------------------------------------
// tb_router_output_channel
//
// Directed bench for router_output_channel. Inputs change and outputs are
// sampled on the falling clock edge; the DUT captures on the rising edge.
// Expected read data is queued by the bench as it builds each packet.
// ---------------------------------------------------------------------------
module tb_router_output_channel;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       packet_valid_in;
    logic [7:0] channel;
    logic       vld_chan;
    logic       read_enb;
    logic       err;
    logic       suspend_data_in;
    logic       overflow;

    int         n_vec;
    int         n_err;
    logic [7:0] exp_q[$];
    logic [7:0] par;
    logic       exp_err;

    router_output_channel #(
        .DEPTH        (128),
        .AW           (7),
        .SUSPEND_FREE (65)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .data_in         (data_in),
        .packet_valid_in (packet_valid_in),
        .channel         (channel),
        .vld_chan        (vld_chan),
        .read_enb        (read_enb),
        .err             (err),
        .suspend_data_in (suspend_data_in),
        .overflow        (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Present one qualified byte; returns at the next falling edge.
    task automatic send(input logic [7:0] b);
        packet_valid_in = 1'b1;
        data_in         = b;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        packet_valid_in = 1'b0;
        data_in         = 8'h00;
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Pop n bytes back to back, checking each against the expected queue.
    task automatic pop_bytes(input int n);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            read_enb = 1'b1;
            @(negedge clock);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            chk_val("rd_data", channel, e);
        end
        read_enb = 1'b0;
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        reset           = 1'b0;
        data_in         = 8'h00;
        packet_valid_in = 1'b0;
        read_enb        = 1'b0;
`ifdef ROUTER_OUTPUT_CHANNEL_PARITY_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clock);
        chk_val("rst_channel", channel, 8'h00);
        chk_val("rst_vld", 8'(vld_chan), 8'h00);
        chk_val("rst_err", 8'(err), 8'h00);
        chk_val("rst_susp", 8'(suspend_data_in), 8'h00);
        chk_val("rst_ovf", 8'(overflow), 8'h00);
        reset = 1'b1;
        read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk_val("empty_rd_channel", channel, 8'h00);
            chk_val("empty_rd_vld", 8'(vld_chan), 8'h00);
        end
        read_enb = 1'b0;

        // Good packet L=3
        send(8'h0C); send(8'h11); send(8'h22); send(8'h33);
        chk_val("good_vld_pre", 8'(vld_chan), 8'h00);
        send(8'h0C);
        chk_val("good_vld", 8'(vld_chan), 8'h01);
        chk_val("good_err", 8'(err), 8'h00);
        idle(1);
        chk_val("good_err2", 8'(err), 8'h00);
        exp_q.push_back(8'h0C); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h0C);
        pop_bytes(5);
        chk_val("good_vld_fall", 8'(vld_chan), 8'h00);

        // Same packet with wrong parity byte 0x00
        send(8'h0C); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
        chk_val("bad_err", 8'(err), 8'(exp_err));
        chk_val("bad_vld", 8'(vld_chan), 8'h01);
        idle(1);
        chk_val("bad_err_pulse", 8'(err), 8'h00);
        exp_q.push_back(8'h0C); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h00);
        pop_bytes(5);
        chk_val("bad_vld_fall", 8'(vld_chan), 8'h00);

        // Store-and-forward with a stall, reader requesting throughout
        read_enb = 1'b1;
        send(8'h08);
        chk_val("sf_hold0", channel, 8'h00);
        send(8'hA5);
        chk_val("sf_hold1", channel, 8'h00);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk_val("sf_stall_ch", channel, 8'h00);
            chk_val("sf_stall_vld", 8'(vld_chan), 8'h00);
        end
        send(8'h5A);
        chk_val("sf_hold2", channel, 8'h00);
        send(8'hF7);
        chk_val("sf_commit_vld", 8'(vld_chan), 8'h01);
        chk_val("sf_commit_ch", channel, 8'h00);
        packet_valid_in = 1'b0;
        exp_q.push_back(8'h08); exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A); exp_q.push_back(8'hF7);
        pop_bytes(4);
        chk_val("sf_vld_fall", 8'(vld_chan), 8'h00);
        chk_val("sf_err", 8'(err), 8'h00);

        // Overflow: two L=63 packets, reader idle
        par = 8'hFC;
        send(8'hFC);
        exp_q.push_back(8'hFC);
        for (int i = 1; i <= 63; i++) begin
            send(8'(i));
            exp_q.push_back(8'(i));
            par = par ^ 8'(i);
        end
        send(par);
        exp_q.push_back(par);
        idle(2);
        chk_val("ovf_susp_first", 8'(suspend_data_in), 8'h01);
        chk_val("ovf_vld_first", 8'(vld_chan), 8'h01);
        chk_val("ovf_flag_first", 8'(overflow), 8'h00);
        par = 8'hFC;
        send(8'hFC);
        for (int i = 1; i <= 63; i++) begin
            send(8'(i + 128));
            par = par ^ 8'(i + 128);
        end
        send(par);
        idle(2);
        chk_val("ovf_flag", 8'(overflow), 8'h01);
        chk_val("ovf_vld", 8'(vld_chan), 8'h01);
        chk_val("ovf_susp", 8'(suspend_data_in), 8'h01);
        chk_val("ovf_err", 8'(err), 8'h00);
        pop_bytes(65);
        chk_val("ovf_single_pkt", 8'(vld_chan), 8'h00);
        idle(2);
        chk_val("ovf_susp_clear", 8'(suspend_data_in), 8'h00);
        chk_val("ovf_sticky", 8'(overflow), 8'h01);
        read_enb = 1'b1;
        @(negedge clock);
        chk_val("ovf_no_extra_pop", channel, exp_q.size() == 0 ? par ^ par ^ 8'hFC : 8'hxx);
        read_enb = 1'b0;

        // Mid-packet reset
        send(8'h0C); send(8'h11); send(8'h22);
        packet_valid_in = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk_val("mrst_vld", 8'(vld_chan), 8'h00);
        chk_val("mrst_susp", 8'(suspend_data_in), 8'h00);
        chk_val("mrst_ovf", 8'(overflow), 8'h00);
        chk_val("mrst_channel", channel, 8'h00);
        reset = 1'b1;
        idle(1);
        send(8'h05); send(8'h3C); send(8'h39);
        chk_val("mrst_new_vld", 8'(vld_chan), 8'h01);
        idle(1);
        exp_q.push_back(8'h05); exp_q.push_back(8'h3C); exp_q.push_back(8'h39);
        pop_bytes(3);
        chk_val("mrst_new_vld_fall", 8'(vld_chan), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_output_channel.md
# router_output_channel

Store-and-forward output buffer for one router channel. Three instances sit directly downstream of the router input stage, one per channel. Each captures the byte stream qualified by its `packet_valid_N` line, stores whole packets in a circular byte FIFO, and checks even parity. It presents only fully received packets to the external reader through a `vld_chan_N` / `read_enb_N` handshake, and drives flow control (`suspend_data_in`) back to the packet source.

## Interface
- `DEPTH`, default 128: FIFO capacity in bytes; power of two, at least 65 (largest packet).
- `AW`, default 7: log2(`DEPTH`); pointer width.
- `SUSPEND_FREE`, default 65: `suspend_data_in` asserts when free entries fall below this value.

Ports (clock and reset first):
- `clock`  input  1  Single clock; all state changes on the rising edge.
- `reset`  input  1  Asynchronous, active-low reset (asserted at 0).
- `data_in`  input  8  Byte stream from the input stage.
- `packet_valid_in`  input  1  Channel select/valid from the input stage; qualifies `data_in`.
- `channel`  output  8  Registered read data; reset 0.
- `vld_chan`  output  1  High while at least one complete packet is stored; reset 0.
- `read_enb`  input  1  Reader pop request.
- `err`  output  1  One-cycle parity-error pulse; reset 0.
- `suspend_data_in`  output  1  Registered low-space indication; reset 0.
- `overflow`  output  1  Sticky packet-dropped flag; cleared only by reset; reset 0.

## Operation
- Packet format:
  - Header: bits [7:2] = length L (0..63), bits [1:0] = address.
  - L payload bytes follow.
  - One parity byte: XOR of the header and all payload bytes.
  - Total L+2 bytes.
- Write FSM states: W_IDLE, W_DATA, W_PAR, W_DRAIN.
  - W_IDLE: on an edge with `packet_valid_in`=1, write the header. Load `remain`=L and `par_acc`=header. Set `wr_start` to the header address. Go to W_DATA, or to W_PAR if L=0.
  - W_DATA: write each qualified byte, XOR it into `par_acc`, and decrement `remain`. At `remain`=1, go to W_PAR.
  - W_PAR: write the qualified byte as parity, then commit: `pkt_count`+1 and `wr_commit`=`wr_ptr`+1. Go to W_DRAIN.
  - W_DRAIN: ignore bytes until `packet_valid_in`=0, then go to W_IDLE.
  - Cycles with `packet_valid_in`=0 in W_DATA or W_PAR are stalls: no write, no state change.
- Overflow: a write attempt with the FIFO full (`wr_ptr` − `rd_ptr` = `DEPTH`) discards the partial packet.
  - Rewind `wr_ptr` to `wr_start`, set `overflow`, go to W_DRAIN.
  - `pkt_count` is unchanged.
- Read side: a pop occurs on an edge with `read_enb`=1 and `pkt_count`≠0. Uncommitted bytes are never readable.
  - The pop loads `channel` with `mem[rd_ptr]` and increments `rd_ptr`.
  - A read counter takes L from each header popped. After that packet's parity byte pops, `pkt_count` decrements.
- `read_enb` with `pkt_count`=0 is ignored; `channel` holds its value.
- Simultaneous commit and final-byte pop: `pkt_count` is unchanged.
- Pointers are AW+1 bits; wrap is modulo 2·`DEPTH`. Occupancy = `wr_ptr` − `rd_ptr`.

## Timing
- Write capture: the byte is stored at the edge where `packet_valid_in`=1.
- `vld_chan` rises the cycle after the parity-byte edge and falls the cycle after the last committed packet's parity byte pops.
- Read latency: 1. The byte on `channel` is valid the cycle after the `read_enb` edge. Back-to-back pops stream one byte per cycle.
- `err`: high for exactly the one cycle following the parity edge.
- `suspend_data_in`: registered from the occupancy after each edge, asserted when free entries < `SUSPEND_FREE`. One-cycle lag from the occupancy change.
- Reset assertion at any time, including mid-packet or mid-read: all pointers, counters, FSMs and outputs return to their reset values immediately. Stored data is lost.

## Configuration
- `ROUTER_OUTPUT_CHANNEL_PARITY_CHECK_EN`:
  - Defined: the parity byte is compared with `par_acc`. A mismatch pulses `err`. The packet is still committed.
  - Undefined: `par_acc` logic is removed, `err` is tied to 0, and the parity byte is stored unchecked.

## Test plan
- Reset state: hold `reset`=0 → all outputs 0. Then release, drive `read_enb`=1 for 5 cycles with no packets → `channel` stays 0 and `vld_chan` stays 0.
- Good packet: header 0x0C (L=3), payload 0x11 0x22 0x33, parity 0x0C^0x11^0x22^0x33=0x0C → `vld_chan`=1 one cycle after parity, `err` stays 0. A 5-cycle `read_enb` burst yields 0x0C 0x11 0x22 0x33 0x0C at 1-cycle latency, and `vld_chan` falls after the last pop.
- Bad parity (macro defined): same packet with parity 0x00 → `err` pulses for 1 cycle, the packet is still readable, and its parity byte reads back as 0x00.
- Store-and-forward with stalls: L=2 with a 3-cycle `packet_valid_in`=0 gap mid-payload, and `read_enb` held high throughout → no pops before commit, and all 4 bytes read correctly after commit.
- Overflow: `DEPTH`=128; write one L=63 packet (65 bytes), then a second L=63 packet while the reader idles → `suspend_data_in`=1 after the first packet. The second packet is dropped at the full point, `overflow`=1, `pkt_count`=1, and the first packet reads back intact.
- Mid-packet reset: drop `reset` to 0 after the 2nd payload byte → `vld_chan`=0 and `suspend_data_in`=0. After release, a fresh L=1 packet is stored and read correctly.
